decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 128 ++++++++++++
 rtl/decode_regfile.sv | 44 ++++
 rtl/decode_stage.sv | 138 +++++++++++++
 tb/tb_decode_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared encodings and the combinational RV32 instruction decoder for the decode stage.
// Immediates come out 32 bits wide; the stage sign-extends them to XLEN.
package decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_ADD_PC = 4'd10;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef struct packed {
        logic        regwrite;
        result_src_e result_src;
        logic        memwrite;
        logic        jump;
        logic        branch;
        logic [3:0]  alu_control;
        logic [2:0]  branch_control;
        logic        alu_src;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        uses_rd;
        logic        illegal;
        logic [31:0] imm;
    } decode_ctrl_t;

    function automatic logic [3:0] alu_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

    function automatic decode_ctrl_t decode(input logic [31:0] ins);
        decode_ctrl_t d;
        logic [31:0]  imm_i;
        d     = '0;
        imm_i = {{20{ins[31]}}, ins[31:20]};
        case (ins[6:0])
            OP_LOAD: begin
                d.regwrite = 1'b1; d.result_src = RES_MEM; d.alu_src = 1'b1;
                d.uses_rs1 = 1'b1; d.uses_rd = 1'b1; d.imm = imm_i;
            end
            OP_STORE: begin
                d.memwrite = 1'b1; d.alu_src = 1'b1; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1;
                d.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            OP_IMM: begin
                // bit 30 only selects SRAI; for other OP-IMM it is immediate data
                d.regwrite = 1'b1; d.alu_src = 1'b1; d.uses_rs1 = 1'b1; d.uses_rd = 1'b1;
                d.alu_control = alu_op(ins[14:12], ins[30] && (ins[14:12] == 3'b101));
                d.imm = imm_i;
            end
            OP_REG: begin
                d.regwrite = 1'b1; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.uses_rd = 1'b1;
                d.alu_control = alu_op(ins[14:12], ins[30]);
            end
            OP_BRANCH: begin
                d.branch = 1'b1; d.alu_control = ALU_SUB; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1;
                d.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                case (ins[14:12])
                    3'b000:  d.branch_control = BR_EQ;
                    3'b001:  d.branch_control = BR_NE;
                    3'b100:  d.branch_control = BR_LT;
                    3'b101:  d.branch_control = BR_GE;
                    3'b110:  d.branch_control = BR_LTU;
                    3'b111:  d.branch_control = BR_GEU;
                    default: d.illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                d.regwrite = 1'b1; d.jump = 1'b1; d.result_src = RES_PC4; d.uses_rd = 1'b1;
                d.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            OP_JALR: begin
                d.regwrite = 1'b1; d.jump = 1'b1; d.result_src = RES_PC4; d.alu_src = 1'b1;
                d.uses_rs1 = 1'b1; d.uses_rd = 1'b1; d.imm = imm_i;
            end
            OP_LUI: begin
                d.regwrite = 1'b1; d.result_src = RES_IMM; d.uses_rd = 1'b1;
                d.imm = {ins[31:12], 12'b0};
            end
            OP_AUIPC: begin
                d.regwrite = 1'b1; d.alu_src = 1'b1; d.alu_control = ALU_ADD_PC; d.uses_rd = 1'b1;
                d.imm = {ins[31:12], 12'b0};
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// Architectural register file: one write port, two combinational read ports with write-through.
// x0 and indices at or above NREGS always read as zero.
module decode_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [4:0]      rs1_idx,
    input  logic [4:0]      rs2_idx,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
);
    localparam int          RW       = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [5:0]  LP_NREGS = 6'(NREGS);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_ok;
    logic            w_rs1_ok;
    logic            w_rs2_ok;

    assign w_wr_ok  = wb_en && (wb_rd != 5'd0) && ({1'b0, wb_rd} < LP_NREGS);
    assign w_rs1_ok = (rs1_idx != 5'd0) && ({1'b0, rs1_idx} < LP_NREGS);
    assign w_rs2_ok = (rs2_idx != 5'd0) && ({1'b0, rs2_idx} < LP_NREGS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[wb_rd[RW-1:0]] <= wb_data;
        end
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (w_rs1_ok) rs1_data = (w_wr_ok && wb_rd == rs1_idx) ? wb_data : r_regs[rs1_idx[RW-1:0]];
        if (w_rs2_ok) rs2_data = (w_wr_ok && wb_rd == rs2_idx) ? wb_data : r_regs[rs2_idx[RW-1:0]];
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes the fetched instruction, reads operands and holds the ID/EX register.
// Inserts a single bubble on load-use and lets a flush override everything.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_plus_4,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            flush_d,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] immediate,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [4:0]      rs1_idx,
    output logic [4:0]      rs2_idx,
    output logic [4:0]      rd_out,
    output logic            regwrite_d,
    output logic [1:0]      result_src_d,
    output logic            memwrite_d,
    output logic            jump_d,
    output logic            branch_d,
    output logic [3:0]      alu_control_d,
    output logic [2:0]      branch_control_d,
    output logic            alu_src_d,
    output logic            illegal_d,
    output logic [XLEN-1:0] id_ex_pc,
    output logic [XLEN-1:0] id_ex_pc_plus_4,
    output logic            hazard_stall
);
    localparam logic [5:0] LP_NREGS = 6'(NREGS);

    decode_ctrl_t    w_dec;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic            w_oob;
    logic            w_illegal;
    logic            w_accept;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    assign w_dec     = decode(instruction);
    assign w_rs1     = instruction[19:15];
    assign w_rs2     = instruction[24:20];
    assign w_rd      = instruction[11:7];
    assign w_imm     = XLEN'($signed(w_dec.imm));
    assign w_oob     = (w_dec.uses_rs1 && ({1'b0, w_rs1} >= LP_NREGS))
                    || (w_dec.uses_rs2 && ({1'b0, w_rs2} >= LP_NREGS))
                    || (w_dec.uses_rd  && ({1'b0, w_rd}  >= LP_NREGS));
    assign w_illegal = w_dec.illegal || w_oob;

    // Load in ID/EX whose destination is needed by the instruction now in fetch
    assign hazard_stall = out_valid && regwrite_d && (result_src_d == RES_MEM) && (rd_out != 5'd0)
                       && in_valid && ((w_dec.uses_rs1 && w_rs1 == rd_out)
                                    || (w_dec.uses_rs2 && w_rs2 == rd_out));
    assign in_ready = (!out_valid || out_ready) && !hazard_stall;
    assign w_accept = in_valid && in_ready;

    decode_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .rs1_idx  (w_rs1),
        .rs2_idx  (w_rs2),
        .rs1_data (w_rs1_data),
        .rs2_data (w_rs2_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid        <= 1'b0;
            immediate        <= '0;
            rs1_data         <= '0;
            rs2_data         <= '0;
            rs1_idx          <= '0;
            rs2_idx          <= '0;
            rd_out           <= '0;
            regwrite_d       <= 1'b0;
            result_src_d     <= '0;
            memwrite_d       <= 1'b0;
            jump_d           <= 1'b0;
            branch_d         <= 1'b0;
            alu_control_d    <= '0;
            branch_control_d <= '0;
            alu_src_d        <= 1'b0;
            illegal_d        <= 1'b0;
            id_ex_pc         <= '0;
            id_ex_pc_plus_4  <= '0;
        end else if (flush_d) begin
            out_valid        <= 1'b0;
            regwrite_d       <= 1'b0;
            result_src_d     <= '0;
            memwrite_d       <= 1'b0;
            jump_d           <= 1'b0;
            branch_d         <= 1'b0;
            alu_control_d    <= '0;
            branch_control_d <= '0;
            alu_src_d        <= 1'b0;
            illegal_d        <= 1'b0;
        end else if (w_accept) begin
            out_valid        <= 1'b1;
            immediate        <= w_imm;
            rs1_data         <= w_oob ? '0 : w_rs1_data;
            rs2_data         <= w_oob ? '0 : w_rs2_data;
            rs1_idx          <= w_rs1;
            rs2_idx          <= w_rs2;
            rd_out           <= w_rd;
            regwrite_d       <= w_dec.regwrite && !w_illegal;
            result_src_d     <= w_dec.result_src;
            memwrite_d       <= w_dec.memwrite && !w_illegal;
            jump_d           <= w_dec.jump && !w_illegal;
            branch_d         <= w_dec.branch && !w_illegal;
            alu_control_d    <= w_dec.alu_control;
            branch_control_d <= w_dec.branch_control;
            alu_src_d        <= w_dec.alu_src;
            illegal_d        <= w_illegal;
            id_ex_pc         <= pc;
            id_ex_pc_plus_4  <= pc_plus_4;
        end else if (out_valid && out_ready) begin
            out_valid        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (XLEN=32, NREGS=16) with hand-computed expectations.
module tb_decode_stage;
    localparam int XLEN  = 32;
    localparam int NREGS = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     instruction = '0;
    logic [XLEN-1:0] pc = '0;
    logic [XLEN-1:0] pc_plus_4 = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            flush_d = 1'b0;
    logic            wb_en = 1'b0;
    logic [4:0]      wb_rd = '0;
    logic [XLEN-1:0] wb_data = '0;
    logic [XLEN-1:0] immediate, rs1_data, rs2_data, id_ex_pc, id_ex_pc_plus_4;
    logic [4:0]      rs1_idx, rs2_idx, rd_out;
    logic            regwrite_d, memwrite_d, jump_d, branch_d, alu_src_d, illegal_d, hazard_stall;
    logic [1:0]      result_src_d;
    logic [3:0]      alu_control_d;
    logic [2:0]      branch_control_d;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc(pc), .pc_plus_4(pc_plus_4),
        .out_valid(out_valid), .out_ready(out_ready), .flush_d(flush_d),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .immediate(immediate), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_out(rd_out),
        .regwrite_d(regwrite_d), .result_src_d(result_src_d), .memwrite_d(memwrite_d),
        .jump_d(jump_d), .branch_d(branch_d), .alu_control_d(alu_control_d),
        .branch_control_d(branch_control_d), .alu_src_d(alu_src_d), .illegal_d(illegal_d),
        .id_ex_pc(id_ex_pc), .id_ex_pc_plus_4(id_ex_pc_plus_4), .hazard_stall(hazard_stall)
    );

    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_REG  = 7'b0110011;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
        tick;
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
        checks++;
        if ({regwrite_d, illegal_d, immediate} !== '0) begin failures++; $display("FAIL reset_regs got=%0h exp=0", {regwrite_d, illegal_d, immediate}); end
    endtask

    task automatic test_basic;
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        tick;
        wb_en = 1'b0;
        pc = 32'h100; pc_plus_4 = 32'h104;
        instruction = {7'd0, 5'd0, 5'd5, 3'd0, 5'd6, OPC_REG};   // add x6,x5,x0
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%0h exp=1", out_valid); end
        checks++;
        if (rs1_data !== 32'h1234) begin failures++; $display("FAIL basic_rs1_data got=%0h exp=1234", rs1_data); end
        checks++;
        if (rs2_data !== 32'h0) begin failures++; $display("FAIL basic_rs2_data got=%0h exp=0", rs2_data); end
        checks++;
        if ({rd_out, regwrite_d} !== {5'd6, 1'b1}) begin failures++; $display("FAIL basic_rd_regwrite got=%0h exp=%0h", {rd_out, regwrite_d}, {5'd6, 1'b1}); end
        checks++;
        if ({id_ex_pc, id_ex_pc_plus_4} !== {32'h100, 32'h104}) begin failures++; $display("FAIL basic_pc got=%0h exp=%0h", {id_ex_pc, id_ex_pc_plus_4}, {32'h100, 32'h104}); end
        tick;
        checks++;
        if ({out_valid, rs1_data} !== {1'b0, 32'h1234}) begin failures++; $display("FAIL basic_drain got=%0h exp=%0h", {out_valid, rs1_data}, {1'b0, 32'h1234}); end
    endtask

    task automatic test_bypass;
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD;
        instruction = {12'd1, 5'd7, 3'd0, 5'd8, OPC_IMM};        // addi x8,x7,1
        in_valid = 1'b1;
        tick;
        wb_en = 1'b0;
        checks++;
        if ({rs1_data, immediate} !== {32'hDEAD, 32'h1}) begin failures++; $display("FAIL bypass_data got=%0h exp=%0h", {rs1_data, immediate}, {32'hDEAD, 32'h1}); end
        instruction = {7'd0, 5'd0, 5'd7, 3'd0, 5'd9, OPC_REG};   // add x9,x7,x0
        tick;
        in_valid = 1'b0;
        checks++;
        if (rs1_data !== 32'hDEAD) begin failures++; $display("FAIL bypass_stored got=%0h exp=dead", rs1_data); end
        tick;
    endtask

    task automatic test_load_use;
        instruction = {12'd0, 5'd2, 3'b010, 5'd3, OPC_LOAD};     // lw x3,0(x2)
        in_valid = 1'b1;
        tick;
        checks++;
        if ({out_valid, result_src_d, rd_out} !== {1'b1, 2'b01, 5'd3}) begin failures++; $display("FAIL lu_load got=%0h exp=%0h", {out_valid, result_src_d, rd_out}, {1'b1, 2'b01, 5'd3}); end
        instruction = {7'd0, 5'd1, 5'd3, 3'd0, 5'd4, OPC_REG};   // add x4,x3,x1
        #1;
        checks++;
        if ({hazard_stall, in_ready} !== 2'b10) begin failures++; $display("FAIL lu_stall got=%0h exp=2", {hazard_stall, in_ready}); end
        tick;
        checks++;
        if ({out_valid, hazard_stall, in_ready} !== 3'b001) begin failures++; $display("FAIL lu_bubble got=%0h exp=1", {out_valid, hazard_stall, in_ready}); end
        tick;
        checks++;
        if ({out_valid, rd_out, rs1_idx} !== {1'b1, 5'd4, 5'd3}) begin failures++; $display("FAIL lu_accept got=%0h exp=%0h", {out_valid, rd_out, rs1_idx}, {1'b1, 5'd4, 5'd3}); end
        instruction = {12'd0, 5'd2, 3'b010, 5'd0, OPC_LOAD};     // lw x0,0(x2)
        tick;
        instruction = {7'd0, 5'd1, 5'd0, 3'd0, 5'd4, OPC_REG};   // add x4,x0,x1
        #1;
        checks++;
        if ({hazard_stall, in_ready} !== 2'b01) begin failures++; $display("FAIL lu_x0_nohazard got=%0h exp=1", {hazard_stall, in_ready}); end
        tick;
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_stall;
        instruction = {12'h055, 5'd0, 3'd0, 5'd10, OPC_IMM};     // addi x10,x0,0x55
        in_valid = 1'b1;
        tick;
        out_ready = 1'b0;
        instruction = {12'd7, 5'd0, 3'd0, 5'd11, OPC_IMM};        // addi x11,x0,7
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cycle=%0d got=%0h exp=0", i, in_ready); end
            tick;
            checks++;
            if ({out_valid, rd_out, immediate} !== {1'b1, 5'd10, 32'h55}) begin failures++; $display("FAIL stall_hold cycle=%0d got=%0h exp=%0h", i, {out_valid, rd_out, immediate}, {1'b1, 5'd10, 32'h55}); end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release got=%0h exp=1", in_ready); end
        tick;
        in_valid = 1'b0;
        checks++;
        if ({rd_out, immediate} !== {5'd11, 32'h7}) begin failures++; $display("FAIL stall_next got=%0h exp=%0h", {rd_out, immediate}, {5'd11, 32'h7}); end
        tick;
        checks++;
        if ({out_valid, regwrite_d} !== 2'b01) begin failures++; $display("FAIL stall_drain got=%0h exp=1", {out_valid, regwrite_d}); end
    endtask

    task automatic test_flush;
        instruction = {7'h7F, 5'd5, 5'd2, 3'b010, 5'h1C, 7'b0100011}; // sw x5,-4(x2)
        in_valid = 1'b1;
        flush_d = 1'b1;
        tick;
        flush_d = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, regwrite_d, memwrite_d} !== 3'b000) begin failures++; $display("FAIL flush_ctrl got=%0h exp=0", {out_valid, regwrite_d, memwrite_d}); end
    endtask

    task automatic test_decode_table;
        logic [31:0] t_ins [11];
        logic [31:0] t_imm [11];
        logic [14:0] t_ctl [11];
        // ctl = {regwrite, result_src, memwrite, jump, branch, alu_control, branch_control, alu_src, illegal}
        t_ins = '{ {7'h7F, 5'd5, 5'd2, 3'b010, 5'h1C, 7'b0100011},
                   {1'b1, 6'h3F, 5'd2, 5'd1, 3'b001, 4'b1100, 1'b1, 7'b1100011},
                   {20'h12345, 5'd9, 7'b0110111},
                   {1'b0, 10'd0, 1'b1, 8'd0, 5'd1, 7'b1101111},
                   32'h0000007F,
                   {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, OPC_REG},
                   {7'b0100000, 5'd4, 5'd1, 3'b101, 5'd3, OPC_IMM},
                   {20'hFFFFF, 5'd5, 7'b0010111},
                   {12'hFFF, 5'd2, 3'b000, 5'd1, 7'b1100111},
                   {7'd0, 5'd3, 5'd2, 3'b111, 5'd1, OPC_REG},
                   {12'd8, 5'd2, 3'b010, 5'd3, OPC_LOAD} };
        t_imm = '{ 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800, 32'h0, 32'h0,
                   32'h00000404, 32'hFFFFF000, 32'hFFFFFFFF, 32'h0, 32'h8 };
        t_ctl = '{ {1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0,  3'd0, 1'b1, 1'b0},
                   {1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 4'd1,  3'd1, 1'b0, 1'b0},
                   {1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 4'd0,  3'd0, 1'b0, 1'b0},
                   {1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 4'd0,  3'd0, 1'b0, 1'b0},
                   {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0,  3'd0, 1'b0, 1'b1},
                   {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4'd1,  3'd0, 1'b0, 1'b0},
                   {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4'd7,  3'd0, 1'b1, 1'b0},
                   {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4'd10, 3'd0, 1'b1, 1'b0},
                   {1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 4'd0,  3'd0, 1'b1, 1'b0},
                   {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4'd9,  3'd0, 1'b0, 1'b0},
                   {1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 4'd0,  3'd0, 1'b1, 1'b0} };
        for (int i = 0; i < 11; i++) begin
            instruction = t_ins[i];
            in_valid = 1'b1;
            tick;
            checks++;
            if (immediate !== t_imm[i]) begin failures++; $display("FAIL dec_imm entry=%0d got=%0h exp=%0h", i, immediate, t_imm[i]); end
            checks++;
            if ({regwrite_d, result_src_d, memwrite_d, jump_d, branch_d, alu_control_d, branch_control_d, alu_src_d, illegal_d} !== t_ctl[i]) begin
                failures++;
                $display("FAIL dec_ctl entry=%0d got=%0h exp=%0h", i,
                         {regwrite_d, result_src_d, memwrite_d, jump_d, branch_d, alu_control_d, branch_control_d, alu_src_d, illegal_d}, t_ctl[i]);
            end
        end
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_regs16;
        instruction = {12'd5, 5'd0, 3'd0, 5'd20, OPC_IMM};        // addi x20,x0,5
        in_valid = 1'b1;
        tick;
        checks++;
        if ({illegal_d, regwrite_d, immediate} !== {1'b1, 1'b0, 32'h5}) begin failures++; $display("FAIL r16_rd_oob got=%0h exp=%0h", {illegal_d, regwrite_d, immediate}, {1'b1, 1'b0, 32'h5}); end
        instruction = {7'd0, 5'd0, 5'd20, 3'd0, 5'd5, OPC_REG};  // add x5,x20,x0
        tick;
        checks++;
        if ({illegal_d, regwrite_d, rs1_data} !== {1'b1, 1'b0, 32'h0}) begin failures++; $display("FAIL r16_rs_oob got=%0h exp=%0h", {illegal_d, regwrite_d, rs1_data}, {1'b1, 1'b0, 32'h0}); end
        instruction = {12'd0, 5'd5, 3'd0, 5'd15, OPC_IMM};        // addi x15,x5,0
        tick;
        in_valid = 1'b0;
        checks++;
        if ({illegal_d, regwrite_d, rs1_data} !== {1'b0, 1'b1, 32'h1234}) begin failures++; $display("FAIL r16_edge got=%0h exp=%0h", {illegal_d, regwrite_d, rs1_data}, {1'b0, 1'b1, 32'h1234}); end
        tick;
    endtask

    task automatic test_reset_mid_stall;
        instruction = {12'd0, 5'd2, 3'b010, 5'd3, OPC_LOAD};     // lw x3,0(x2)
        in_valid = 1'b1;
        tick;
        out_ready = 1'b0;
        instruction = {7'd0, 5'd1, 5'd3, 3'd0, 5'd4, OPC_REG};   // add x4,x3,x1
        tick;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, regwrite_d, result_src_d, rd_out, immediate, id_ex_pc, hazard_stall} !== '0) begin
            failures++;
            $display("FAIL rst_async got=%0h exp=0", {out_valid, regwrite_d, result_src_d, rd_out, immediate, id_ex_pc, hazard_stall});
        end
        out_ready = 1'b1;
        instruction = {7'd0, 5'd0, 5'd5, 3'd0, 5'd6, OPC_REG};   // add x6,x5,x0
        #2 reset_n = 1'b1;
        tick;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
        tick;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, rs1_data} !== {1'b1, 32'h0}) begin failures++; $display("FAIL rst_regs_cleared got=%0h exp=%0h", {out_valid, rs1_data}, {1'b1, 32'h0}); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_bypass;
        test_load_use;
        test_stall;
        test_flush;
        test_decode_table;
        test_regs16;
        test_reset_mid_stall;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
